// File: rtl/sgpr_arb_pkg.sv
// sgpr_arb_pkg: shared sizes and requester indices for the SGPR read arbiter
package sgpr_arb_pkg;
    localparam int NUM_REQ    = 8;
    localparam int ADDR_W     = 9;
    localparam int DATA_W     = 32;
    localparam int RD_LAT_DEF = 1;
    localparam int IDX_W      = $clog2(NUM_REQ);
    localparam int REQ_SIMD0  = 0;
    localparam int REQ_SIMD1  = 1;
    localparam int REQ_SIMD2  = 2;
    localparam int REQ_SIMD3  = 3;
    localparam int REQ_SIMF0  = 4;
    localparam int REQ_SIMF1  = 5;
    localparam int REQ_SIMF2  = 6;
    localparam int REQ_SIMF3  = 7;
endpackage

// File: rtl/sgpr_rd_arbiter_if.sv
// sgpr_rd_arbiter_if: requester and SGPR-port signals of the read arbiter
interface sgpr_rd_arbiter_if;
    import sgpr_arb_pkg::*;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      port_stall;
    logic                      sgpr_rd_en;
    logic [ADDR_W-1:0]         sgpr_rd_addr;
    logic [NUM_REQ-1:0]        sgpr_select_fu;
    logic [DATA_W-1:0]         sgpr_rd_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      arb_idle;
    modport slave (
        input  req_valid, req_addr, port_stall, sgpr_rd_data,
        output req_ready, sgpr_rd_en, sgpr_rd_addr, sgpr_select_fu, rsp_valid, rsp_data, arb_idle
    );
    modport master (
        output req_valid, req_addr, port_stall, sgpr_rd_data,
        input  req_ready, sgpr_rd_en, sgpr_rd_addr, sgpr_select_fu, rsp_valid, rsp_data, arb_idle
    );
endinterface

// File: rtl/rr_picker.sv
// rr_picker: first pending index at or after the round-robin pointer, wrapping
module rr_picker
    import sgpr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_pending,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx
);
    logic w_found;
    int   w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = (int'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_pending[w_j]) begin
                w_found       = 1'b1;
                o_grant[w_j]  = 1'b1;
                o_idx         = IDX_W'(w_j);
            end
        end
    end
endmodule

// File: rtl/sgpr_rd_arbiter.sv
// sgpr_rd_arbiter: round-robin share of the SGPR vector read port among eight
// SIMD/SIMF units, one pending slot each, tagged one-hot response return.
module sgpr_rd_arbiter
    import sgpr_arb_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    sgpr_rd_arbiter_if.slave bus
);
    logic [NUM_REQ-1:0] r_pending;
    logic [IDX_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]  r_slot [NUM_REQ];
    logic               r_rd_en;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [NUM_REQ-1:0] r_sel;
    logic [NUM_REQ-1:0] r_tag [RD_LAT];
    logic [NUM_REQ-1:0] w_pick;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_ready;
    logic [NUM_REQ-1:0] w_accept;
    logic [IDX_W-1:0]   w_idx;
    logic               w_tag_any;

    rr_picker u_pick (
        .i_pending (r_pending),
        .i_ptr     (r_ptr),
        .o_grant   (w_pick),
        .o_idx     (w_idx)
    );

    assign w_grant  = bus.port_stall ? '0 : w_pick;
    assign w_ready  = ~r_pending | w_grant;
    assign w_accept = bus.req_valid & w_ready;

    always_comb begin
        w_tag_any = 1'b0;
        for (int s = 0; s < RD_LAT; s++) w_tag_any = w_tag_any | (|r_tag[s]);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++)
            if (w_accept[i]) r_slot[i] <= bus.req_addr[i*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_ptr     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_sel     <= '0;
            for (int s = 0; s < RD_LAT; s++) r_tag[s] <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant) | w_accept;
            r_rd_en   <= |w_grant;
            r_sel     <= w_grant;
            if (|w_grant) begin
                r_ptr     <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
                r_rd_addr <= r_slot[w_idx];
            end
            // tag pipe mirrors sgpr latency so the owner lines up with returning data
            r_tag[0] <= r_sel;
            for (int s = 1; s < RD_LAT; s++) r_tag[s] <= r_tag[s-1];
        end
    end

    assign bus.req_ready      = w_ready;
    assign bus.sgpr_rd_en     = r_rd_en;
    assign bus.sgpr_rd_addr   = r_rd_addr;
    assign bus.sgpr_select_fu = r_sel;
    assign bus.rsp_valid      = r_tag[RD_LAT-1];
    assign bus.rsp_data       = bus.sgpr_rd_data;
    assign bus.arb_idle       = (r_pending == '0) && !r_rd_en && !w_tag_any;
endmodule
